// File: rtl/md_defs.sv
// Shared definitions for the multiply/divide unit.
//   - MDOp operation encodings (3 bits, sampled with Start)
//   - default busy latencies for multiply and divide
//   - FSM state encoding (IDLE / RUN)
package md_defs;

    localparam logic [2:0] MD_NONE  = 3'd0;
    localparam logic [2:0] MD_MULT  = 3'd1;
    localparam logic [2:0] MD_MULTU = 3'd2;
    localparam logic [2:0] MD_DIV   = 3'd3;
    localparam logic [2:0] MD_DIVU  = 3'd4;
    localparam logic [2:0] MD_MTHI  = 3'd5;
    localparam logic [2:0] MD_MTLO  = 3'd6;

    localparam int MD_MULT_CYCLES_DEF = 5;
    localparam int MD_DIV_CYCLES_DEF  = 10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

endpackage

// File: rtl/md_div_core.sv
// Combinational 32-bit divider with signed/unsigned selection.
// Ports:
//   a           in  32  dividend
//   b           in  32  divisor
//   is_signed   in  1   1 = treat a/b as two's complement
//   quo         out 32  quotient, truncated toward zero
//   rem         out 32  remainder, carries the sign of the dividend
//   div_by_zero out 1   b == 0 (quo/rem are forced to 0 and must be ignored)
module md_div_core (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        is_signed,
    output logic [31:0] quo,
    output logic [31:0] rem,
    output logic        div_by_zero
);

    logic        a_neg_s;
    logic        b_neg_s;
    logic [31:0] a_mag_s;
    logic [31:0] b_mag_s;
    logic [31:0] b_safe_s;
    logic [31:0] uq_s;
    logic [31:0] ur_s;
    logic        overflow_s;

    // Divide magnitudes unsigned, then restore signs.
    always_comb begin
        a_neg_s     = is_signed & a[31];
        b_neg_s     = is_signed & b[31];
        a_mag_s     = a_neg_s ? (32'd0 - a) : a;
        b_mag_s     = b_neg_s ? (32'd0 - b) : b;
        div_by_zero = (b == 32'd0);
        // Keep the divider's input legal on B=0; the result is discarded anyway.
        b_safe_s    = div_by_zero ? 32'd1 : b_mag_s;
        uq_s        = a_mag_s / b_safe_s;
        ur_s        = a_mag_s % b_safe_s;
        // Most-negative / -1 does not fit; the architectural answer is the dividend itself.
        overflow_s  = is_signed && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);

        if (div_by_zero) begin
            quo = 32'd0;
            rem = 32'd0;
        end else if (overflow_s) begin
            quo = 32'h8000_0000;
            rem = 32'd0;
        end else begin
            quo = (a_neg_s ^ b_neg_s) ? (32'd0 - uq_s) : uq_s;
            rem = a_neg_s ? (32'd0 - ur_s) : ur_s;
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit owning the HI/LO register pair.
// The result is computed at acceptance and parked in pending registers; HI/LO
// are only updated when the fixed latency expires, so they show old values
// while Busy is high.
// Ports:
//   clk   in  1   system clock, rising edge
//   rst_n in  1   asynchronous active-low reset
//   A     in  32  rs operand (dividend / multiplicand / mthi-mtlo source)
//   B     in  32  rt operand (divisor / multiplier)
//   MDOp  in  3   operation code, sampled only with Start
//   Start in  1   single-cycle request strobe
//   Busy  out 1   operation in flight
//   HI    out 32  HI register
//   LO    out 32  LO register
module mult_div_unit
    import md_defs::*;
#(
    parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [2:0]  MDOp,
    input  logic        Start,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [15:0] MULT_LOAD = 16'(MULT_CYCLES - 1);
    localparam logic [15:0] DIV_LOAD  = 16'(DIV_CYCLES - 1);

    md_state_e   state_r, state_n;
    logic [15:0] cnt_r,   cnt_n;
    logic        busy_r,  busy_n;
    logic [31:0] hi_r,    hi_n;
    logic [31:0] lo_r,    lo_n;
    logic [31:0] phi_r,   phi_n;
    logic [31:0] plo_r,   plo_n;
    logic        pwr_r,   pwr_n;

    logic        mul_signed_s;
    logic [63:0] mul_a_s;
    logic [63:0] mul_b_s;
    logic [63:0] prod_s;
    logic        div_signed_s;
    logic [31:0] div_quo_s;
    logic [31:0] div_rem_s;
    logic        div_zero_s;

    // Sign-extend (or zero-extend) to 64 bits; the low 64 bits of the product are then exact.
    always_comb begin
        mul_signed_s = (MDOp == MD_MULT);
        mul_a_s      = {{32{mul_signed_s & A[31]}}, A};
        mul_b_s      = {{32{mul_signed_s & B[31]}}, B};
        prod_s       = mul_a_s * mul_b_s;
        div_signed_s = (MDOp == MD_DIV);
    end

    md_div_core u_div (
        .a           (A),
        .b           (B),
        .is_signed   (div_signed_s),
        .quo         (div_quo_s),
        .rem         (div_rem_s),
        .div_by_zero (div_zero_s)
    );

    // Next-state, counter and HI/LO/pending update logic.
    always_comb begin
        state_n = state_r;
        cnt_n   = cnt_r;
        busy_n  = busy_r;
        hi_n    = hi_r;
        lo_n    = lo_r;
        phi_n   = phi_r;
        plo_n   = plo_r;
        pwr_n   = pwr_r;

        case (state_r)
            ST_IDLE: begin
                if (Start) begin
                    case (MDOp)
                        MD_MULT, MD_MULTU: begin
                            phi_n   = prod_s[63:32];
                            plo_n   = prod_s[31:0];
                            pwr_n   = 1'b1;
                            cnt_n   = MULT_LOAD;
                            busy_n  = 1'b1;
                            state_n = ST_RUN;
                        end
                        MD_DIV, MD_DIVU: begin
                            phi_n   = div_rem_s;
                            plo_n   = div_quo_s;
                            // Divide by zero still occupies the unit but leaves HI/LO alone.
                            pwr_n   = ~div_zero_s;
                            cnt_n   = DIV_LOAD;
                            busy_n  = 1'b1;
                            state_n = ST_RUN;
                        end
                        MD_MTHI: hi_n = A;
                        MD_MTLO: lo_n = A;
                        default: ;
                    endcase
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_RUN: begin
                // Start is ignored throughout RUN, including the final cycle.
                if (cnt_r == 16'd0) begin
                    state_n = ST_IDLE;
                    busy_n  = 1'b0;
                    if (pwr_r) begin
                        hi_n = phi_r;
                        lo_n = plo_r;
                    end else begin
                        hi_n = hi_r;
                    end
                end else begin
                    cnt_n = cnt_r - 16'd1;
                end
            end
            default: begin
                state_n = ST_IDLE;
                busy_n  = 1'b0;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= 16'd0;
            busy_r  <= 1'b0;
            hi_r    <= 32'd0;
            lo_r    <= 32'd0;
            phi_r   <= 32'd0;
            plo_r   <= 32'd0;
            pwr_r   <= 1'b0;
        end else begin
            state_r <= state_n;
            cnt_r   <= cnt_n;
            busy_r  <= busy_n;
            hi_r    <= hi_n;
            lo_r    <= lo_n;
            phi_r   <= phi_n;
            plo_r   <= plo_n;
            pwr_r   <= pwr_n;
        end
    end

    assign Busy = busy_r;
    assign HI   = hi_r;
    assign LO   = lo_r;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed cases followed by random
// operations, all compared against an arithmetic HI/LO model.
module tb_mult_div_unit;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk;
    logic        rst_n;
    logic [31:0] A;
    logic [31:0] B;
    logic [2:0]  MDOp;
    logic        Start;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int          vectors;
    int          miscompares;
    logic [31:0] mhi;
    logic [31:0] mlo;

    mult_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .A     (A),
        .B     (B),
        .MDOp  (MDOp),
        .Start (Start),
        .Busy  (Busy),
        .HI    (HI),
        .LO    (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference behaviour: what HI/LO must hold once the operation retires.
    task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, p;
        logic [63:0] up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            3'd1: begin p = sa * sb; mhi = p[63:32]; mlo = p[31:0]; end
            3'd2: begin up = {32'd0, a} * {32'd0, b}; mhi = up[63:32]; mlo = up[31:0]; end
            3'd3: if (b != 32'd0) begin p = sa / sb; mlo = p[31:0]; p = sa % sb; mhi = p[31:0]; end
            3'd4: if (b != 32'd0) begin mlo = a / b; mhi = a % b; end
            3'd5: mhi = a;
            3'd6: mlo = a;
            default: ;
        endcase
    endtask

    function automatic int latency(input logic [2:0] op);
        if (op == 3'd1 || op == 3'd2) return MC;
        if (op == 3'd3 || op == 3'd4) return DC;
        return 0;
    endfunction

    // Issue one op from a falling edge, scramble operands afterwards, measure Busy, check HI/LO.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input string tag);
        logic [31:0] old_hi, old_lo;
        int cnt;
        old_hi = mhi;
        old_lo = mlo;
        model(op, a, b);
        A = a; B = b; MDOp = op; Start = 1'b1;
        @(negedge clk);
        Start = 1'b0;
        A = $urandom; B = $urandom; MDOp = 3'($urandom_range(0, 7));
        cnt = 0;
        while (Busy === 1'b1 && cnt < 64) begin
            if (cnt == 0) begin
                chk({tag, "_hold_hi"}, HI, old_hi);
                chk({tag, "_hold_lo"}, LO, old_lo);
            end
            cnt++;
            @(negedge clk);
        end
        chk({tag, "_busy_len"}, 32'(cnt), 32'(latency(op)));
        chk({tag, "_hi"}, HI, mhi);
        chk({tag, "_lo"}, LO, mlo);
    endtask

    initial begin
        int cnt;
        logic [2:0]  rop;
        logic [31:0] ra, rb;
        vectors = 0; miscompares = 0;
        mhi = 32'd0; mlo = 32'd0;
        rst_n = 1'b0; A = 32'd0; B = 32'd0; MDOp = 3'd0; Start = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_busy", {31'd0, Busy}, 32'd0);
        chk("reset_hi", HI, 32'd0);
        chk("reset_lo", LO, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // mthi/mtlo: single cycle, Busy never rises.
        run_op(3'd6, 32'hDEADBEEF, 32'd0, "mtlo");
        run_op(3'd5, 32'h0BADF00D, 32'd0, "mthi");

        // Signed vs unsigned multiply.
        run_op(3'd1, 32'hFFFFFFFF, 32'd2, "mult_neg");
        chk("mult_neg_hi_lit", HI, 32'hFFFFFFFF);
        chk("mult_neg_lo_lit", LO, 32'hFFFFFFFE);
        run_op(3'd2, 32'hFFFFFFFF, 32'd2, "multu");
        chk("multu_hi_lit", HI, 32'h00000001);
        chk("multu_lo_lit", LO, 32'hFFFFFFFE);

        // Signed divide, including the overflow corner.
        run_op(3'd3, 32'hFFFFFFF9, 32'd2, "div_neg");
        chk("div_neg_lo_lit", LO, 32'hFFFFFFFD);
        chk("div_neg_hi_lit", HI, 32'hFFFFFFFF);
        run_op(3'd3, 32'h80000000, 32'hFFFFFFFF, "div_ovf");
        chk("div_ovf_lo_lit", LO, 32'h80000000);
        chk("div_ovf_hi_lit", HI, 32'h00000000);

        // Divide by zero keeps preloaded HI/LO.
        run_op(3'd5, 32'h1111, 32'd0, "pre_hi");
        run_op(3'd6, 32'h2222, 32'd0, "pre_lo");
        run_op(3'd4, 32'd7, 32'd0, "divu_zero");
        chk("divu_zero_hi_lit", HI, 32'h1111);
        chk("divu_zero_lo_lit", LO, 32'h2222);

        // No-op codes do nothing.
        run_op(3'd0, 32'h5555, 32'h1, "op_none");
        run_op(3'd7, 32'h6666, 32'h1, "op_rsvd");

        // Start while busy: T+1 and T+10 requests are both dropped.
        A = 32'd100; B = 32'd7; MDOp = 3'd3; Start = 1'b1;
        @(negedge clk);
        A = 32'd9; B = 32'd9; MDOp = 3'd2; Start = 1'b1;
        cnt = 0;
        while (Busy === 1'b1 && cnt < 64) begin
            cnt++;
            Start = (cnt == 1 || cnt == DC) ? 1'b1 : 1'b0;
            @(negedge clk);
        end
        Start = 1'b0;
        mlo = 32'd14; mhi = 32'd2;
        chk("busy_start_len", 32'(cnt), 32'(DC));
        chk("busy_start_lo", LO, 32'd14);
        chk("busy_start_hi", HI, 32'd2);
        @(negedge clk);
        chk("busy_start_dropped", {31'd0, Busy}, 32'd0);
        chk("busy_start_lo2", LO, 32'd14);

        // Operand change after acceptance (run_op scrambles A/B at T+1).
        run_op(3'd1, 32'h12345678, 32'hFEDCBA98, "opnd_change");

        // Random operations with corner-heavy operand selection.
        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = 32'hFFFFFFFF;
                2: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
                3: rb = 32'($urandom_range(1, 20));
                default: ;
            endcase
            run_op(rop, ra, rb, "rand");
        end

        // Asynchronous reset in the middle of RUN.
        A = 32'd3; B = 32'd4; MDOp = 3'd1; Start = 1'b1;
        @(negedge clk);
        Start = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        mhi = 32'd0; mlo = 32'd0;
        chk("rst_mid_busy", {31'd0, Busy}, 32'd0);
        chk("rst_mid_hi", HI, 32'd0);
        chk("rst_mid_lo", LO, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_after_busy", {31'd0, Busy}, 32'd0);
        run_op(3'd5, 32'd5, 32'd0, "post_rst_mthi");
        chk("post_rst_hi_lit", HI, 32'd5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
